rf16b_clk_en: RTL and testbench

//  8-entry x 16-bit register file: one write port, two read ports. Each entry is a

---
 rtl/rf16b_clk_en_pkg.sv | 7 +
 rtl/rf16b_clk_en_if.sv | 27 ++
 rtl/rf16b_clk_en_rf_word.sv | 17 +
 rtl/rf16b_clk_en.sv | 75 +++++++
 tb/tb_rf16b_clk_en.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/rf16b_clk_en_pkg.sv
// Shared sizing for the 8 x 16 register file and its bus interface.
package rf16b_clk_en_pkg;
  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 8;
  localparam int RF_AW    = 3;
  localparam int RF_CNT_W = 8;
endpackage

// File: rtl/rf16b_clk_en_if.sv
// Write-back / operand-read bus between the datapath and the register file.
interface rf16b_clk_en_if
  import rf16b_clk_en_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int AW    = RF_AW
) ();
  logic                clk_en;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [AW-1:0]       rd_addr_a;
  logic [AW-1:0]       rd_addr_b;
  logic [WIDTH-1:0]    rd_data_a;
  logic [WIDTH-1:0]    rd_data_b;
  logic [RF_CNT_W-1:0] wr_cnt;

  modport master (
    output clk_en, wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_cnt
  );

  modport slave (
    input  clk_en, wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_cnt
  );
endinterface

// File: rtl/rf16b_clk_en_rf_word.sv
// One clock-enabled register-file word with synchronous clear.
module rf_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk_n) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end
endmodule

// File: rtl/rf16b_clk_en.sv
// 8 x 16 register file: one write port with one-hot word enables, two
// combinational read ports with optional write bypass, committed-write counter.
module rf16b_clk_en
  import rf16b_clk_en_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int DEPTH   = RF_DEPTH,
  parameter int AW      = RF_AW,
  parameter bit R0_ZERO = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input logic          clk_n,
  input logic          rst,
  rf16b_clk_en_if.slave bus
);
  logic                commit;
  logic                wr_r0;
  logic                wr_store;
  logic [DEPTH-1:0]    word_en;
  logic [WIDTH-1:0]    word_q [DEPTH];
  logic [WIDTH-1:0]    rd_a;
  logic [WIDTH-1:0]    rd_b;
  logic [RF_CNT_W-1:0] cnt;

  // A request is accepted (and counted) even when it targets a hardwired-zero entry.
  assign commit   = !rst && bus.clk_en && bus.wr_en;
  assign wr_r0    = R0_ZERO && (bus.wr_addr == '0);
  assign wr_store = commit && !wr_r0;

  always_comb begin
    word_en = '0;
    if (wr_store)
      word_en[bus.wr_addr] = 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    rf_word #(.WIDTH(WIDTH)) u_word (
      .clk_n (clk_n),
      .rst   (rst),
      .en    (word_en[i]),
      .d     (bus.wr_data),
      .q     (word_q[i])
    );
  end

  function automatic logic [WIDTH-1:0] rd_sel(
    input logic [AW-1:0]    addr,
    input logic [WIDTH-1:0] stored
  );
    logic [WIDTH-1:0] r;
    r = stored;
    if (BYPASS && wr_store && (addr == bus.wr_addr))
      r = bus.wr_data;
    if (R0_ZERO && (addr == '0))
      r = '0;
    return r;
  endfunction

  always_comb begin
    rd_a = rd_sel(bus.rd_addr_a, word_q[bus.rd_addr_a]);
    rd_b = rd_sel(bus.rd_addr_b, word_q[bus.rd_addr_b]);
  end

  assign bus.rd_data_a = rd_a;
  assign bus.rd_data_b = rd_b;

  always_ff @(posedge clk_n) begin
    if (rst)
      cnt <= '0;
    else if (commit)
      cnt <= cnt + 1'b1;
  end

  assign bus.wr_cnt = cnt;
endmodule

// File: tb/tb_rf16b_clk_en.sv
// Directed bench: two register files (R0 writable + bypass, R0 hardwired + no bypass)
// driven with identical stimulus and checked against hand-computed values.
module tb_rf16b_clk_en;
  import rf16b_clk_en_pkg::*;

  logic        clk_n = 1'b0;
  logic        rst, clk_en, wr_en;
  logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [15:0] wr_data;
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] fill_v [8] = '{16'h1111, 16'h2222, 16'h4444, 16'h8888,
                              16'hCCCC, 16'hFFFF, 16'h1234, 16'hABCD};

  always #5 clk_n = ~clk_n;

  rf16b_clk_en_if ifa ();
  rf16b_clk_en_if ifb ();

  assign ifa.clk_en    = clk_en;
  assign ifa.wr_en     = wr_en;
  assign ifa.wr_addr   = wr_addr;
  assign ifa.wr_data   = wr_data;
  assign ifa.rd_addr_a = rd_addr_a;
  assign ifa.rd_addr_b = rd_addr_b;
  assign ifb.clk_en    = clk_en;
  assign ifb.wr_en     = wr_en;
  assign ifb.wr_addr   = wr_addr;
  assign ifb.wr_data   = wr_data;
  assign ifb.rd_addr_a = rd_addr_a;
  assign ifb.rd_addr_b = rd_addr_b;

  rf16b_clk_en #(.R0_ZERO(1'b0), .BYPASS(1'b1)) dut_a (
    .clk_n (clk_n),
    .rst   (rst),
    .bus   (ifa.slave)
  );

  rf16b_clk_en #(.R0_ZERO(1'b1), .BYPASS(1'b0)) dut_b (
    .clk_n (clk_n),
    .rst   (rst),
    .bus   (ifb.slave)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_n);
    #1;
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] exp);
    chk({tag, "_cnt_a"}, {8'h00, ifa.wr_cnt}, {8'h00, exp});
    chk({tag, "_cnt_b"}, {8'h00, ifb.wr_cnt}, {8'h00, exp});
  endtask

  initial begin
    // Reset wins over a concurrent write request
    rst = 1'b1; clk_en = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hDDDD;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    step();
    rst = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      #1;
      chk($sformatf("rst_a%0d", i), ifa.rd_data_a, 16'h0000);
      chk($sformatf("rst_b%0d", i), ifb.rd_data_b, 16'h0000);
    end
    chk_cnt("rst", 8'h00);

    // Gated write: nothing commits, no bypass, then enabled write lands
    clk_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hDDDD; rd_addr_a = 3'd3;
    #1;
    chk("gate_byp_a", ifa.rd_data_a, 16'h0000);
    step();
    wr_en = 1'b0;
    #1;
    chk("gate_hold_a", ifa.rd_data_a, 16'h0000);
    chk("gate_hold_b", ifb.rd_data_a, 16'h0000);
    chk_cnt("gate", 8'h00);
    clk_en = 1'b1;
    do_write(3'd3, 16'hDDDD);
    #1;
    chk("gate_wr_a", ifa.rd_data_a, 16'hDDDD);
    chk("gate_wr_b", ifb.rd_data_a, 16'hDDDD);
    chk_cnt("gate_wr", 8'h01);

    // Fill all entries from a fresh reset
    do_reset();
    for (int i = 0; i < 8; i++) do_write(3'(i), fill_v[i]);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(i);
      #1;
      chk($sformatf("fill_aa%0d", i), ifa.rd_data_a, fill_v[i]);
      chk($sformatf("fill_ab%0d", i), ifa.rd_data_b, fill_v[i]);
      chk($sformatf("fill_ba%0d", i), ifb.rd_data_a, (i == 0) ? 16'h0000 : fill_v[i]);
      chk($sformatf("fill_bb%0d", i), ifb.rd_data_b, (i == 0) ? 16'h0000 : fill_v[i]);
    end
    chk_cnt("fill", 8'h08);

    // Read-during-write on entry 5
    do_write(3'd5, 16'h1111);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h2222; rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    #1;
    chk("byp_aa", ifa.rd_data_a, 16'h2222);
    chk("byp_ab", ifa.rd_data_b, 16'h2222);
    chk("byp_ba", ifb.rd_data_a, 16'h1111);
    chk("byp_bb", ifb.rd_data_b, 16'h1111);
    step();
    wr_en = 1'b0;
    #1;
    chk("byp_post_a", ifa.rd_data_a, 16'h2222);
    chk("byp_post_b", ifb.rd_data_b, 16'h2222);
    wr_en = 1'b1; wr_data = 16'h3333; rd_addr_b = 3'd6;
    #1;
    chk("byp_ind_aa", ifa.rd_data_a, 16'h3333);
    chk("byp_ind_ab", ifa.rd_data_b, 16'h1234);
    step();
    wr_en = 1'b0;
    // R0 hardwired entry ignores a write and never bypasses
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h5555; rd_addr_a = 3'd0;
    #1;
    chk("r0_byp_a", ifa.rd_data_a, 16'h5555);
    chk("r0_byp_b", ifb.rd_data_a, 16'h0000);
    step();
    wr_en = 1'b0;
    #1;
    chk("r0_wr_a", ifa.rd_data_a, 16'h5555);
    chk("r0_wr_b", ifb.rd_data_a, 16'h0000);
    chk_cnt("r0", 8'h0C);

    // Reset between two writes drops the second one
    do_write(3'd2, 16'h5A5A);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h7777;
    step();
    rst = 1'b0; wr_en = 1'b0; rd_addr_a = 3'd2; rd_addr_b = 3'd4;
    #1;
    chk("mid_a2", ifa.rd_data_a, 16'h0000);
    chk("mid_a4", ifa.rd_data_b, 16'h0000);
    chk("mid_b2", ifb.rd_data_a, 16'h0000);
    chk("mid_b4", ifb.rd_data_b, 16'h0000);
    chk_cnt("mid", 8'h00);
    do_write(3'd1, 16'h0F0F);
    rd_addr_a = 3'd1;
    #1;
    chk("mid_wr_a", ifa.rd_data_a, 16'h0F0F);
    chk("mid_wr_b", ifb.rd_data_a, 16'h0F0F);
    chk_cnt("mid_wr", 8'h01);

    // Counter wrap after 256 commits from reset
    do_reset();
    for (int i = 0; i < 255; i++) do_write(3'(i), 16'(i));
    chk_cnt("wrap_ff", 8'hFF);
    do_write(3'd7, 16'hBEEF);
    chk_cnt("wrap_00", 8'h00);
    clk_en = 1'b0; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    chk_cnt("wrap_hold", 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
